// File: rtl/mem_access.sv
// Memory-access stage: latches execute results, runs loads over the data-memory
// read port (stalling while outstanding) and formats stores for commit after write-back.
module mem_access (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_INST,
  input  logic        E_VALID,
  input  logic [4:0]  E_REG_D,
  input  logic [31:0] E_REG_D_V,
  input  logic        E_MEM_RDEN,
  input  logic        E_MEM_WREN,
  input  logic [31:0] E_MEM_ADDR,
  input  logic [2:0]  E_MEM_FUNCT3,
  input  logic [31:0] E_STORE_DATA,
  output logic        DMEM_RDEN,
  output logic [31:0] DMEM_RADDR,
  input  logic        DMEM_RREADY,
  input  logic [31:0] DMEM_RDATA,
  output logic [31:0] M_PC,
  output logic [31:0] M_INST,
  output logic        M_VALID,
  output logic [4:0]  M_REG_D,
  output logic [31:0] M_REG_D_V,
  output logic        M_STORE_WREN,
  output logic [31:0] M_STORE_ADDR,
  output logic [3:0]  M_STORE_STRB,
  output logic [31:0] M_STORE_DATA,
  output logic        M_STALL_REQ
);

  // state  | meaning
  // IDLE   | no load outstanding; stage follows the latch enable
  // BUSY   | load issued, waiting for DMEM_RREADY; pipeline stalled
  // DONE   | load data captured; held until the next latch-enable edge
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [4:0]  reg_d_q, reg_d_d;
  logic [31:0] alu_q, alu_d;
  logic        wren_q, wren_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] ldata_q, ldata_d;

  logic        busy;
  logic        le;

  assign busy = (state_q == S_BUSY);
  assign le   = !STALL && !busy;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    reg_d_d  = reg_d_q;
    alu_d    = alu_q;
    wren_d   = wren_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    sdata_d  = sdata_q;
    ldata_d  = ldata_q;
    if (busy) begin
      if (DMEM_RREADY) begin
        state_d = S_DONE;
        ldata_d = DMEM_RDATA;
      end
    end else if (le) begin
      if (FLUSH) begin
        state_d  = S_IDLE;
        pc_d     = '0;
        inst_d   = '0;
        valid_d  = 1'b0;
        reg_d_d  = '0;
        alu_d    = '0;
        wren_d   = 1'b0;
        addr_d   = '0;
        funct3_d = '0;
        sdata_d  = '0;
        ldata_d  = '0;
      end else begin
        state_d  = (E_VALID && E_MEM_RDEN) ? S_BUSY : S_IDLE;
        pc_d     = E_PC;
        inst_d   = E_INST;
        valid_d  = E_VALID;
        reg_d_d  = E_REG_D;
        alu_d    = E_REG_D_V;
        // a load flag overrides a simultaneous store flag
        wren_d   = E_MEM_WREN && !E_MEM_RDEN;
        addr_d   = E_MEM_ADDR;
        funct3_d = E_MEM_FUNCT3;
        sdata_d  = E_STORE_DATA;
        ldata_d  = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
      reg_d_q  <= '0;
      alu_q    <= '0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      funct3_q <= '0;
      sdata_q  <= '0;
      ldata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      reg_d_q  <= reg_d_d;
      alu_q    <= alu_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      sdata_q  <= sdata_d;
      ldata_q  <= ldata_d;
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'd0:    ld_byte = ldata_q[7:0];
      2'd1:    ld_byte = ldata_q[15:8];
      2'd2:    ld_byte = ldata_q[23:16];
      default: ld_byte = ldata_q[31:24];
    endcase
    ld_half = addr_q[1] ? ldata_q[31:16] : ldata_q[15:0];
    ld_ext  = '0;
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = ldata_q;
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = '0;
    endcase
  end

  logic        st_code_ok;
  logic        st_en;
  logic [3:0]  st_strb;
  logic [31:0] st_data;

  always_comb begin
    st_code_ok = 1'b1;
    st_strb    = 4'h0;
    st_data    = '0;
    case (funct3_q)
      3'b000: begin
        st_strb = 4'b0001 << addr_q[1:0];
        st_data = {4{sdata_q[7:0]}};
      end
      3'b001: begin
        st_strb = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{sdata_q[15:0]}};
      end
      3'b010: begin
        st_strb = 4'b1111;
        st_data = sdata_q;
      end
      default: st_code_ok = 1'b0;
    endcase
  end

  assign st_en = valid_q && wren_q && st_code_ok;

  assign DMEM_RDEN    = busy;
  assign DMEM_RADDR   = busy ? {addr_q[31:2], 2'b00} : 32'h0;
  assign M_STALL_REQ  = busy;
  assign M_PC         = pc_q;
  assign M_INST       = inst_q;
  assign M_VALID      = valid_q;
  assign M_REG_D      = reg_d_q;
  assign M_REG_D_V    = busy ? 32'h0 : ((state_q == S_DONE) ? ld_ext : alu_q);
  assign M_STORE_WREN = st_en;
  assign M_STORE_ADDR = st_en ? {addr_q[31:2], 2'b00} : 32'h0;
  assign M_STORE_STRB = st_en ? st_strb : 4'h0;
  assign M_STORE_DATA = st_en ? st_data : 32'h0;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage of the RV32I core. Sits between execute and write-back.
- Latches execute-stage results and performs loads over a request/ready data-memory read port, stalling the pipeline while a load is outstanding.
- Formats stores (word address, byte strobe, lane-replicated data) and passes them downstream as M_* signals. Stores are committed after write-back.

Parameters:
- none

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- STALL  in  1  global hold from hazard controller
- FLUSH  in  1  clear stage contents (insert bubble)
- E_PC  in  32  instruction PC
- E_INST  in  32  instruction word
- E_VALID  in  1  instruction valid
- E_REG_D  in  5  destination register
- E_REG_D_V  in  32  ALU result (non-memory instructions)
- E_MEM_RDEN  in  1  instruction is a load
- E_MEM_WREN  in  1  instruction is a store
- E_MEM_ADDR  in  32  effective byte address
- E_MEM_FUNCT3  in  3  load/store width code
- E_STORE_DATA  in  32  rs2 value for stores
- DMEM_RDEN  out  1  read request
- DMEM_RADDR  out  32  word-aligned read address
- DMEM_RREADY  in  1  read data valid this cycle
- DMEM_RDATA  in  32  read data
- M_PC, M_INST  out  32 each  latched PC, instruction
- M_VALID  out  1  latched valid
- M_REG_D  out  5  destination register
- M_REG_D_V  out  32  ALU result, or extended load data for loads
- M_STORE_WREN  out  1  store enable
- M_STORE_ADDR  out  32  word-aligned store address
- M_STORE_STRB  out  4  byte strobe
- M_STORE_DATA  out  32  lane-replicated store data
- M_STALL_REQ  out  1  stage requests global stall

Behaviour:
- Clock/reset: single clock CLK; RST synchronous, active-high. RST clears all registers and sets FSM=IDLE. All outputs are 0 after reset.
- Latch enable: LE = !STALL && state!=BUSY. Priority at each edge: RST > hold (!LE) > FLUSH > capture E_*.
- FLUSH with LE=1: zero all latched fields, valid=0, state=IDLE.
- FSM states IDLE, BUSY, DONE:
  - IDLE/DONE -> BUSY when LE, !FLUSH, E_VALID and E_MEM_RDEN at the edge.
  - IDLE/DONE -> IDLE when LE captures any other instruction or applies FLUSH.
  - BUSY: DMEM_RDEN=1, DMEM_RADDR={addr[31:2],2'b00}, M_STALL_REQ=1.
  - BUSY -> DONE on an edge with DMEM_RREADY=1; DMEM_RDATA is captured into the load register at that edge.
  - BUSY ignores STALL and FLUSH. A flush arriving during BUSY is re-presented by the controller once the stage releases.
  - DONE holds until the next LE edge. M_STALL_REQ=0 in DONE.
- DMEM_RDEN and M_STALL_REQ are 0 outside BUSY. DMEM_RADDR=0 outside BUSY.
- Load latency: the load is latched at edge N; BUSY begins in cycle N+1. With RREADY in that cycle, DONE begins at N+2. Minimum stall is therefore 1 cycle.
- M_REG_D_V:
  - For a latched load, equals the extended load data in DONE and 0 in BUSY.
  - Otherwise equals the latched E_REG_D_V.
- Load extraction, lane = addr[1:0]:
  - LB 000: sign-extend byte[lane].
  - LH 001: sign-extend halfword[addr[1]].
  - LW 010: full word.
  - LBU 100: zero-extend byte[lane].
  - LHU 101: zero-extend halfword[addr[1]].
  - Other codes: 0.
  - Misaligned half/word accesses ignore the offending low address bits; no trap is raised.
- Store formatting, computed from latched fields:
  - Enable: M_STORE_WREN = valid & wren.
  - Address: M_STORE_ADDR = {addr[31:2],2'b00}.
  - SB: strobe 4'b0001<<lane; data {4{rs2[7:0]}}.
  - SH: strobe 4'b0011<<(2*addr[1]); data {2{rs2[15:0]}}.
  - SW: strobe 4'b1111; data rs2.
  - Other codes: strobe 0, wren 0.
  - When not a valid store: strobe, addr and data are all 0.
- Pass-through fields: M_PC, M_INST, M_VALID and M_REG_D come directly from the latch registers.
- Store and load flags both set: the load takes precedence and the store is suppressed.
- A load with E_VALID=0 does not enter BUSY.

Test Plan:
- Reset then ALU op: E_REG_D=5, E_REG_D_V=0x1234 -> next cycle M_REG_D=5, M_REG_D_V=0x1234, M_STALL_REQ=0, DMEM_RDEN=0.
- LB at addr 0x103, RDATA=0x80FF_FF00 with RREADY one cycle after BUSY -> DMEM_RADDR=0x100; stall for 2 cycles; M_REG_D_V=0xFFFF_FF80 in DONE. Repeat as LBU -> 0x0000_0080.
- LH at addr 0x102 with RDATA=0x8001_7FFF -> 0xFFFF_8001. LHU -> 0x0000_8001. LW -> 0x8001_7FFF.
- SB rs2=0xAABB_CCDD at addr 0x201 -> WREN=1, ADDR=0x200, STRB=0010, DATA=0xDDDD_DDDD. SH at addr 0x202 -> STRB=1100, DATA=0xCCDD_CCDD.
- STALL held 3 cycles during an ALU op, with E_* changing -> outputs frozen. FLUSH with STALL=0 -> M_VALID=0 and all M_* = 0.
- Load in BUSY with STALL=0, FLUSH=1, RREADY withheld 4 cycles -> stays BUSY with stall asserted and FLUSH ignored. RST mid-BUSY -> IDLE next cycle, DMEM_RDEN=0, all outputs 0.
